// File: rtl/fmc_frame_scheduler.sv
// Servo-frame scheduler: round-robin collection of one sample per producer into a back bank,
// then an atomic publish to the FMC-visible front bank once the STM32 is off the bus.
module fmc_frame_scheduler #(
  parameter int NCH         = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  input  logic [NCH-1:0]       src_req,
  input  logic [16*NCH-1:0]    src_data,
  output logic [NCH-1:0]       src_ack,
  input  logic                 fpga_cs_ne1,
  output logic [16*NCH-1:0]    frame_data,
  output logic [15:0]          frame_seq,
  output logic                 frame_valid,
  output logic [NCH-1:0]       stale_mask,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int PW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_BUS, SWAP} state_t;

  state_t         state;
  logic [NCH-1:0] captured;
  logic [NCH-1:0] eligible;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] cap_next;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  grant_idx;
  logic [PW-1:0]  hi_idx;
  logic [PW-1:0]  lo_idx;
  logic           grant_valid;
  logic           hi_found;
  logic           lo_found;
  logic [TW-1:0]  tcnt;
  logic [1:0]     cs_sync;
  logic [15:0]    back     [NCH];
  logic [15:0]    src_word [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      src_word[i] = src_data[16*i +: 16];
    end
  end

  // Lowest eligible index at/above rr_ptr wins; otherwise wrap to the lowest eligible overall.
  always_comb begin
    eligible = src_req & ~captured;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    grant_valid = hi_found | lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
    grant_oh    = '0;
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
  end

  assign src_ack  = (state == COLLECT) ? grant_oh : '0;
  assign cap_next = captured | src_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      captured    <= '0;
      rr_ptr      <= '0;
      tcnt        <= '0;
      cs_sync     <= 2'b11;
      frame_data  <= '0;
      frame_seq   <= '0;
      frame_valid <= 1'b0;
      stale_mask  <= '1;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        back[i] <= '0;
      end
    end else begin
      cs_sync     <= {cs_sync[0], fpga_cs_ne1};
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= frame_tick && (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_tick) begin
            captured <= '0;
            tcnt     <= '0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (grant_valid) begin
            back[grant_idx] <= src_word[grant_idx];
            captured        <= cap_next;
            rr_ptr          <= (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
          end
          // A frame completed on its last allowed cycle counts as complete, not timed out.
          if (&cap_next) begin
            state <= WAIT_BUS;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            state       <= WAIT_BUS;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        WAIT_BUS: begin
          if (cs_sync[1]) state <= SWAP;
        end
        SWAP: begin
          for (int i = 0; i < NCH; i++) begin
            if (captured[i]) frame_data[16*i +: 16] <= back[i];
          end
          stale_mask  <= ~captured;
          frame_seq   <= frame_seq + 16'd1;
          frame_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_frame_scheduler.sv
// Self-checking bench for fmc_frame_scheduler: directed and random frames against a
// frame-level reference model (grant order, front bank, stale mask, sequence, pulse timing).
module tb_fmc_frame_scheduler;

  localparam int NCH         = 16;
  localparam int TIMEOUT_CYC = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_tick;
  logic              fpga_cs_ne1;
  logic [NCH-1:0]    src_req;
  logic [NCH-1:0]    src_ack;
  logic [NCH-1:0]    stale_mask;
  logic [16*NCH-1:0] src_data;
  logic [16*NCH-1:0] frame_data;
  logic [15:0]       frame_seq;
  logic              frame_valid;
  logic              overrun;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [15:0]    m_front [NCH];
  logic [15:0]    m_seq;
  logic [NCH-1:0] m_stale;
  int             m_rr;

  always #5 clk = ~clk;

  fmc_frame_scheduler #(.NCH(NCH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_ack     (src_ack),
    .fpga_cs_ne1 (fpga_cs_ne1),
    .frame_data  (frame_data),
    .frame_seq   (frame_seq),
    .frame_valid (frame_valid),
    .stale_mask  (stale_mask),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16*NCH-1:0] frontPacked();
    logic [16*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[16*i +: 16] = m_front[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) m_front[i] = 16'h0000;
    m_seq   = 16'h0000;
    m_stale = '1;
    m_rr    = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_frame_data"}, 256'(frame_data), 256'(0));
    checkOutput({tag, "_frame_seq"}, 256'(frame_seq), 256'(0));
    checkOutput({tag, "_frame_valid"}, 256'(frame_valid), 256'(0));
    checkOutput({tag, "_stale_mask"}, 256'(stale_mask), 256'({NCH{1'b1}}));
    checkOutput({tag, "_overrun"}, 256'(overrun), 256'(0));
    checkOutput({tag, "_timeout_err"}, 256'(timeout_err), 256'(0));
    checkOutput({tag, "_src_ack"}, 256'(src_ack), 256'(0));
  endtask

  function automatic logic [16*NCH-1:0] randData();
    logic [16*NCH-1:0] d;
    for (int i = 0; i < NCH / 2; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // One frame: producers in 'set' hold requests with 'data' from the tick until acked.
  // csRise>0 keeps CS low until that cycle; tickAgain>0 injects a second tick in that cycle.
  task automatic applyStimulus(input string tag, input logic [NCH-1:0] set,
                               input logic [16*NCH-1:0] data, input int csRise,
                               input int tickAgain, input int budget);
    int             order[$];
    int             validCyc, validCnt, toCyc, toCnt, ovCyc, ovCnt, expValid;
    logic [NCH-1:0] lastAck, expAck, one;
    logic [255:0]   oldFront;
    bit             full;

    one = 1;
    order = {};
    for (int k = 0; k < NCH; k++) begin
      if (set[(m_rr + k) % NCH]) order.push_back((m_rr + k) % NCH);
    end
    full     = (set == '1);
    oldFront = 256'(frontPacked());
    validCyc = -1; validCnt = 0; toCyc = -1; toCnt = 0; ovCyc = -1; ovCnt = 0;
    lastAck  = '0;

    src_req     = set;
    src_data    = data;
    frame_tick  = 1'b1;
    fpga_cs_ne1 = (csRise > 0) ? 1'b0 : 1'b1;

    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      frame_tick  = (c == tickAgain);
      src_req     = src_req & ~lastAck;
      fpga_cs_ne1 = (c >= csRise);
      #1;
      expAck = (c - 1 < order.size()) ? (one << order[c-1]) : '0;
      checkOutput($sformatf("%s_ack_c%0d", tag, c), 256'(src_ack), 256'(expAck));
      lastAck = src_ack;
      if (frame_valid) begin validCnt++; if (validCnt == 1) validCyc = c; end
      if (timeout_err) begin toCnt++; if (toCnt == 1) toCyc = c; end
      if (overrun) begin ovCnt++; if (ovCnt == 1) ovCyc = c; end
      if (csRise > 0 && c == csRise + 2)
        checkOutput({tag, "_holdoff_front"}, 256'(frame_data), oldFront);
    end
    frame_tick = 1'b0;
    src_req    = '0;

    foreach (order[k]) m_front[order[k]] = data[16*order[k] +: 16];
    m_stale = ~set;
    m_seq   = m_seq + 16'd1;
    if (order.size() > 0) m_rr = (order[order.size()-1] + 1) % NCH;

    checkOutput({tag, "_valid_count"}, 256'(validCnt), 256'(1));
    if (csRise > 0) begin
      checkOutput({tag, "_valid_window"},
                  256'(validCyc >= csRise + 3 && validCyc <= csRise + 4), 256'(1));
    end else begin
      expValid = full ? NCH + 3 : TIMEOUT_CYC + 3;
      checkOutput({tag, "_valid_cycle"}, 256'(validCyc), 256'(expValid));
    end
    if (full) begin
      checkOutput({tag, "_timeout_count"}, 256'(toCnt), 256'(0));
    end else begin
      checkOutput({tag, "_timeout_count"}, 256'(toCnt), 256'(1));
      checkOutput({tag, "_timeout_cycle"}, 256'(toCyc), 256'(TIMEOUT_CYC + 1));
    end
    if (tickAgain > 0) begin
      checkOutput({tag, "_overrun_count"}, 256'(ovCnt), 256'(1));
      checkOutput({tag, "_overrun_cycle"}, 256'(ovCyc), 256'(tickAgain + 1));
    end else begin
      checkOutput({tag, "_overrun_count"}, 256'(ovCnt), 256'(0));
    end
    checkOutput({tag, "_frame_data"}, 256'(frame_data), 256'(frontPacked()));
    checkOutput({tag, "_stale_mask"}, 256'(stale_mask), 256'(m_stale));
    checkOutput({tag, "_frame_seq"}, 256'(frame_seq), 256'(m_seq));
  endtask

  initial begin
    logic [16*NCH-1:0] data;
    logic [NCH-1:0]    set;
    logic [NCH-1:0]    lastAck;

    rst_n       = 1'b0;
    frame_tick  = 1'b0;
    fpga_cs_ne1 = 1'b1;
    src_req     = '0;
    src_data    = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkReset("init");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NCH; i++) data[16*i +: 16] = 16'hA000 + 16'(i);
    applyStimulus("basic", '1, data, 0, 0, 30);

    applyStimulus("rr1", NCH'(16'h0024), randData(), 0, 0, 30);
    applyStimulus("rr2", NCH'(16'h0224), randData(), 0, 0, 30);

    data = randData();
    data[16*7 +: 16] = 16'h1234;
    applyStimulus("pre_stale", '1, data, 0, 0, 30);
    set = '1;
    set[7] = 1'b0;
    applyStimulus("stale7", set, randData(), 0, 0, 30);
    checkOutput("stale7_front7", 256'(frame_data[16*7 +: 16]), 256'(16'h1234));

    applyStimulus("holdoff", '1, randData(), NCH + 50, 0, NCH + 60);
    applyStimulus("overrun", '1, randData(), 0, 5, 30);

    for (int f = 0; f < 10; f++) begin
      set = ($urandom_range(0, 2) == 0) ? '1 : NCH'($urandom);
      applyStimulus($sformatf("rand%0d", f), set, randData(), 0, 0, 30);
    end

    // Reset in the middle of a frame, after eight captures.
    data       = randData();
    src_req    = '1;
    src_data   = data;
    frame_tick = 1'b1;
    lastAck    = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      src_req    = src_req & ~lastAck;
      #1;
      lastAck = src_ack;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midreset");
    src_req = '0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus("post_reset", '1, randData(), 0, 0, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
